token_divider: RTL and testbench
================================

TOKEN_DIVIDER -- requirements
Module: token_divider

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 4: number of independent 1-bit token channels (1..32).
REQ-002 The block SHALL have parameter CNT_W, default 4: width of the division ratio and per-channel counter.
REQ-003 The block SHALL have parameter RATIO_RST, default 2: active ratio after reset (1..2^CNT_W-1).
REQ-004 The block SHALL have parameter FIRST_RST, default 1: active phase select after reset.
REQ-005 The block SHALL have port clk, input, 1 bit: single clock, all state updates on the rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port cfg_load, input, 1 bit: strobe that applies cfg_ratio and cfg_first.
REQ-008 The block SHALL have port cfg_ratio, input, CNT_W bits: requested ratio N.
REQ-009 The block SHALL have port cfg_first, input, 1 bit: 1 passes the first token of each group of N, 0 passes the last.
REQ-010 The block SHALL have port a, input, CHANNELS bits: incoming token per channel, 1 = token.
REQ-011 The block SHALL have port b, output, CHANNELS bits: outgoing token per channel.
REQ-012 The block SHALL have port pass_cnt, output, CHANNELS*8 bits: per-channel passed-token count, present only with TOKEN_DIVIDER_STATS_EN.

Function
REQ-013 The block SHALL keep active registers ratio_q (CNT_W bits) and first_q (1 bit), plus one counter cnt[i] (CNT_W bits) per channel.
REQ-014 The block SHALL drive b[i] combinationally in the same cycle as a[i] (zero latency): b[i] = a[i] & (first_q ? cnt[i]==0 : cnt[i]==ratio_q-1).
REQ-015 On a[i]=1 with no cfg_load, cnt[i] SHALL wrap to 0 when cnt[i]==ratio_q-1, else increment by 1; on a[i]=0, cnt[i] SHALL hold.
REQ-016 Channels SHALL be fully independent; a token on one channel SHALL never change another channel's counter.
REQ-017 With ratio_q==1, b SHALL equal a for every channel regardless of first_q.
REQ-018 With ratio_q==0, b SHALL be all zero and counters SHALL hold (channel blocked).
REQ-019 On cfg_load=1, ratio_q and first_q SHALL take cfg_ratio and cfg_first at the clock edge, and every cnt[i] SHALL be cleared to 0.
REQ-020 A token arriving in the cfg_load cycle SHALL be evaluated with the old ratio_q/first_q, and it SHALL NOT be counted in the new group.
REQ-021 Counter arithmetic SHALL be unsigned CNT_W bits, and it SHALL never exceed ratio_q-1.

Reset
REQ-022 Asserting rst low SHALL immediately set ratio_q=RATIO_RST, first_q=FIRST_RST, all cnt[i]=0, and all pass_cnt=0, independent of clk.
REQ-023 While rst is low, b SHALL still follow REQ-014 using the reset state; with default parameters this gives b=a.
REQ-024 Reset asserted mid-group SHALL discard the partial group, and the first token after release SHALL start a new group.

Configuration
REQ-025 With macro TOKEN_DIVIDER_STATS_EN defined, the block SHALL provide pass_cnt; each 8-bit field SHALL increment on b[i]=1, saturate at 255, and clear on cfg_load or reset.
REQ-026 Without TOKEN_DIVIDER_STATS_EN, the pass_cnt port and its registers SHALL be absent, and the remaining behaviour SHALL be identical.

Structure
REQ-027 Package token_divider_pkg SHALL hold the STAT_W=8 constant and the default values of CNT_W, RATIO_RST and FIRST_RST.
REQ-028 Per-channel counter, output gating and optional statistic SHALL be implemented in sub-module token_divider_chan, instantiated CHANNELS times by generate.
REQ-029 Shared ratio_q/first_q registers and cfg_load handling SHALL live in token_divider top only.

Verification
REQ-030 The bench SHALL check defaults after reset: ch0 a=1100111010001111 -> b=0100010010000101, matching halve behaviour with first token passed.
REQ-031 The bench SHALL check divide-by-3, last phase: cfg_load ratio=3 first=0, then ch1 a=111111 -> b=001001.
REQ-032 The bench SHALL check ratio edges: ratio=1 -> b==a on all channels for random a; ratio=0 -> b=0 and counters frozen.
REQ-033 The bench SHALL check mid-group reload: ratio=4 first=1, two tokens, then cfg_load ratio=2 together with token -> that token is judged by old state (b=0), and the next token gives b=1.
REQ-034 The bench SHALL check async reset: drop rst between clock edges after 3 tokens at ratio=4 -> cnt=0 immediately, and the next token after release gives b=1 (FIRST_RST=1).
REQ-035 With STATS_EN, the bench SHALL check the statistic: ratio=1, 300 tokens on ch2 -> pass_cnt[ch2]=255 saturated, other channels 0, and cfg_load clears it to 0.

Source files
------------

// File: rtl/token_divider_pkg.sv
// Shared constants for the token divider: statistic width and reset-time defaults.
package token_divider_pkg;
  localparam int STAT_W        = 8;
  localparam int CNT_W_DEF     = 4;
  localparam int RATIO_RST_DEF = 2;
  localparam int FIRST_RST_DEF = 1;
endpackage

// File: rtl/token_divider_if.sv
// Bus bundle for token_divider; pass_cnt exists only with TOKEN_DIVIDER_STATS_EN.
// Tokens have no backpressure: a[i]=1 for one cycle is one token, and b[i] is its
// same-cycle verdict. cfg_load is a single-cycle strobe sampled on the rising edge.
interface token_divider_if
  import token_divider_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = CNT_W_DEF
) ();
  logic                 cfg_load;
  logic [CNT_W-1:0]     cfg_ratio;
  logic                 cfg_first;
  logic [CHANNELS-1:0]  a;
  logic [CHANNELS-1:0]  b;
`ifdef TOKEN_DIVIDER_STATS_EN
  logic [CHANNELS*STAT_W-1:0] pass_cnt;
`endif

  modport master (
    output cfg_load, cfg_ratio, cfg_first, a,
`ifdef TOKEN_DIVIDER_STATS_EN
    input  pass_cnt,
`endif
    input  b
  );

  modport slave (
    input  cfg_load, cfg_ratio, cfg_first, a,
`ifdef TOKEN_DIVIDER_STATS_EN
    output pass_cnt,
`endif
    output b
  );
endinterface

// File: rtl/token_divider_chan.sv
// One token channel: group counter, same-cycle output gating and optional
// saturating pass statistic (TOKEN_DIVIDER_STATS_EN).
module token_divider_chan
  import token_divider_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             a,
  input  logic             first,
  input  logic [CNT_W-1:0] ratio,
`ifdef TOKEN_DIVIDER_STATS_EN
  output logic [STAT_W-1:0] stat,
`endif
  output logic             b
);
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last;
  logic             open;
  logic             hit;

  // A zero ratio blocks the channel entirely, including the first-phase slot.
  assign open = (ratio != '0);
  assign last = ratio - CNT_W'(1);
  assign hit  = first ? (cnt == '0) : (cnt == last);
  assign b    = a & open & hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (a && open) begin
      cnt <= (cnt == last) ? '0 : cnt + CNT_W'(1);
    end
  end

`ifdef TOKEN_DIVIDER_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat <= '0;
    end else if (load) begin
      stat <= '0;
    end else if (b && (stat != '1)) begin
      stat <= stat + STAT_W'(1);
    end
  end
`endif
endmodule

// File: rtl/token_divider.sv
// Per-channel 1-of-N token divider with shared ratio/phase registers.
// Optional per-channel pass statistics with TOKEN_DIVIDER_STATS_EN.
module token_divider
  import token_divider_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int RATIO_RST = RATIO_RST_DEF,
  parameter int FIRST_RST = FIRST_RST_DEF
) (
  input logic            clk,
  input logic            rst,
  token_divider_if.slave bus
);
  logic [CNT_W-1:0]    ratio_q;
  logic                first_q;
  logic [CHANNELS-1:0] b_vec;

  // A token in the load cycle is judged by the old ratio/phase; the channels
  // clear their counters on the same edge so it never joins the new group.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ratio_q <= CNT_W'(RATIO_RST);
      first_q <= 1'(FIRST_RST);
    end else if (bus.cfg_load) begin
      ratio_q <= bus.cfg_ratio;
      first_q <= bus.cfg_first;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    token_divider_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clk   (clk),
      .rst   (rst),
      .load  (bus.cfg_load),
      .a     (bus.a[i]),
      .first (first_q),
      .ratio (ratio_q),
`ifdef TOKEN_DIVIDER_STATS_EN
      .stat  (bus.pass_cnt[i*STAT_W +: STAT_W]),
`endif
      .b     (b_vec[i])
    );
  end

  assign bus.b = b_vec;
endmodule

// File: tb/tb_token_divider.sv
// Directed bench for token_divider; TOKEN_DIVIDER_STATS_EN adds the statistic checks.
module tb_token_divider;
  import token_divider_pkg::*;

  localparam int CH = 4;
  localparam int CW = 4;

  logic clk;
  logic rst;

  token_divider_if #(.CHANNELS(CH), .CNT_W(CW)) bus ();

  token_divider #(
    .CHANNELS  (CH),
    .CNT_W     (CW),
    .RATIO_RST (2),
    .FIRST_RST (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench timeout");
  end

  // scoreboard
  logic [CH-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare_b(input string tag);
    logic [CH-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_empty_q"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'(bus.b), 32'(e));
    end
  endtask

  // drivers: inputs change 1 time unit after the rising edge, b sampled on the falling edge
  task automatic tok(input logic [CH-1:0] av, input logic [CH-1:0] eb, input string tag);
    bus.a = av;
    exp_q.push_back(eb);
    @(negedge clk);
    compare_b(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [CW-1:0] r, input logic f, input logic [CH-1:0] av,
                      input logic [CH-1:0] eb, input string tag);
    bus.cfg_load  = 1'b1;
    bus.cfg_ratio = r;
    bus.cfg_first = f;
    tok(av, eb, tag);
    bus.cfg_load  = 1'b0;
  endtask

  logic [15:0]   pat_a;
  logic [15:0]   pat_b;
  logic [CH-1:0] rnd;

  initial begin
    rst           = 1'b0;
    bus.cfg_load  = 1'b0;
    bus.cfg_ratio = '0;
    bus.cfg_first = 1'b0;
    bus.a         = '0;
    #12;
    // reset state: ratio 2, first phase, so b follows a
    exp_q.push_back(4'b0000);
    compare_b("rst_idle");
    bus.a = 4'b1111;
    #1;
    exp_q.push_back(4'b1111);
    compare_b("rst_b_eq_a");
`ifdef TOKEN_DIVIDER_STATS_EN
    check("rst_pass_cnt", bus.pass_cnt, 32'd0);
`endif
    bus.a = '0;
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // defaults: halve, first token passes; time runs from bit 0
    pat_a = 16'b1100111010001111;
    pat_b = 16'b0100010010000101;
    for (int i = 0; i < 16; i++) begin
      tok({3'b000, pat_a[i]}, {3'b000, pat_b[i]}, $sformatf("dflt_t%0d", i));
    end

    // divide by 3, last phase on ch1
    load(4'd3, 1'b0, 4'b0000, 4'b0000, "ld_div3");
    tok(4'b0010, 4'b0000, "div3_t0");
    tok(4'b0010, 4'b0000, "div3_t1");
    tok(4'b0010, 4'b0010, "div3_t2");
    tok(4'b0010, 4'b0000, "div3_t3");
    tok(4'b0010, 4'b0000, "div3_t4");
    tok(4'b0010, 4'b0010, "div3_t5");

    // ratio 1: b == a in both phases
    load(4'd1, 1'b0, 4'b0000, 4'b0000, "ld_r1_last");
    for (int i = 0; i < 8; i++) begin
      rnd = CH'($urandom_range(0, 15));
      tok(rnd, rnd, $sformatf("r1_last_%0d", i));
    end
    load(4'd1, 1'b1, 4'b0000, 4'b0000, "ld_r1_first");
    for (int i = 0; i < 8; i++) begin
      rnd = CH'($urandom_range(0, 15));
      tok(rnd, rnd, $sformatf("r1_first_%0d", i));
    end

    // ratio 0: blocked, counters frozen
    load(4'd0, 1'b1, 4'b1111, 4'b1111, "ld_r0_oldstate");
    for (int i = 0; i < 8; i++) begin
      rnd = CH'($urandom_range(1, 15));
      tok(rnd, 4'b0000, $sformatf("r0_%0d", i));
    end
    check("r0_cnt_ch0", 32'(dut.g_chan[0].u_chan.cnt), 32'd0);
    check("r0_cnt_ch3", 32'(dut.g_chan[3].u_chan.cnt), 32'd0);

    // mid-group reload: the load-cycle token is judged by the old state
    load(4'd4, 1'b1, 4'b0000, 4'b0000, "ld_r4");
    tok(4'b0001, 4'b0001, "mid_t0");
    tok(4'b0001, 4'b0000, "mid_t1");
    load(4'd2, 1'b1, 4'b0001, 4'b0000, "mid_ld_tok");
    tok(4'b0001, 4'b0001, "mid_new_t0");
    tok(4'b0001, 4'b0000, "mid_new_t1");

    // asynchronous reset mid-group
    load(4'd4, 1'b1, 4'b0000, 4'b0000, "ld_r4_b");
    tok(4'b0001, 4'b0001, "ar_t0");
    tok(4'b0001, 4'b0000, "ar_t1");
    tok(4'b0001, 4'b0000, "ar_t2");
    check("ar_cnt_before", 32'(dut.g_chan[0].u_chan.cnt), 32'd3);
    #2;
    rst = 1'b0;
    #1;
    check("ar_cnt_now", 32'(dut.g_chan[0].u_chan.cnt), 32'd0);
    bus.a = 4'b0001;
    #1;
    exp_q.push_back(4'b0001);
    compare_b("ar_in_reset_b");
    bus.a = 4'b0000;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    tok(4'b0001, 4'b0001, "ar_post_t0");
    tok(4'b0001, 4'b0000, "ar_post_t1");

`ifdef TOKEN_DIVIDER_STATS_EN
    load(4'd1, 1'b1, 4'b0000, 4'b0000, "ld_stat");
    bus.a = 4'b0100;
    repeat (300) @(posedge clk);
    #1;
    bus.a = 4'b0000;
    check("stat_ch2_sat", 32'(bus.pass_cnt[2*STAT_W +: STAT_W]), 32'd255);
    check("stat_ch0", 32'(bus.pass_cnt[0*STAT_W +: STAT_W]), 32'd0);
    check("stat_ch1", 32'(bus.pass_cnt[1*STAT_W +: STAT_W]), 32'd0);
    check("stat_ch3", 32'(bus.pass_cnt[3*STAT_W +: STAT_W]), 32'd0);
    load(4'd1, 1'b1, 4'b0000, 4'b0000, "ld_stat_clr");
    check("stat_clear", bus.pass_cnt, 32'd0);
`endif

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
